// File: rtl/life_grid_sequencer.sv
// Game-of-Life sequencer: owns the NxN state register, paces generations every
// STEP_CYCLES clocks, and stops on a still life or when the generation limit is reached.
module life_grid_sequencer #(
    parameter int N           = 16,
    parameter int STEP_CYCLES = 4,
    parameter int GEN_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               start,
    input  logic               pause,
    input  logic [N*N-1:0]     init_state,
    input  logic [GEN_W-1:0]   max_gen,
    input  logic [N*N-1:0]     grid_evolve,
    output logic [N*N-1:0]     grid,
    output logic [GEN_W-1:0]   generation,
    output logic               running,
    output logic               stable,
    output logic               done,
    output logic [1:0]         dbg_state
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N*N-1:0]   grid_q, grid_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             advance;
    logic [GEN_W-1:0] gen_next;

    assign gen_next = (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + GEN_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            grid_q   <= '0;
            gen_q    <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            gen_q    <= gen_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grid_d   = grid_q;
        gen_d    = gen_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        advance  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    grid_d   = init_state;
                    gen_d    = '0;
                    stable_d = 1'b0;
                end else if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (pause) state_d = S_HOLD;
                else       advance = 1'b1;
            end
            // The edge that leaves HOLD counts as a normal RUN step.
            S_HOLD: begin
                if (!pause) begin
                    state_d = S_RUN;
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                if (load) begin
                    grid_d   = init_state;
                    gen_d    = '0;
                    stable_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (start) begin
                    gen_d    = '0;
                    stable_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (grid_evolve == grid_q) begin
                    stable_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    grid_d = grid_evolve;
                    gen_d  = gen_next;
                    if ((max_gen != '0) && (gen_next == max_gen)) state_d = S_DONE;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign grid       = grid_q;
    assign generation = gen_q;
    assign running    = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign stable     = stable_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_life_grid_sequencer.sv
// Bench for life_grid_sequencer: a Life datapath model feeds grid_evolve, directed
// vectors push hand-computed snapshots into a queue, a negedge monitor pops and compares.
module tb_life_grid_sequencer;

  localparam int N     = 16;
  localparam int GEN_W = 16;
  localparam int W     = N*N + GEN_W + 3 + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic             clk = 1'b0;
  logic             reset, load, start, pause;
  logic [N*N-1:0]   init_state, grid_evolve, grid;
  logic [GEN_W-1:0] max_gen, generation;
  logic             running, stable, done;
  logic [1:0]       dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  logic [N*N-1:0] g_zero, g_blink_v, g_blink_h, g_block;

  life_grid_sequencer #(.N(N), .STEP_CYCLES(4), .GEN_W(GEN_W)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .pause(pause),
    .init_state(init_state), .max_gen(max_gen), .grid_evolve(grid_evolve),
    .grid(grid), .generation(generation), .running(running), .stable(stable),
    .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: one Life generation with dead cells beyond the border.
  function automatic logic [N*N-1:0] life_step(input logic [N*N-1:0] g);
    logic [N*N-1:0] nx;
    nx = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < N && c+dc >= 0 && c+dc < N)
              cnt += int'(g[N*(r+dr) + c+dc]);
        nx[N*r+c] = (cnt == 3) || (g[N*r+c] && cnt == 2);
      end
    end
    return nx;
  endfunction

  always_comb grid_evolve = life_step(grid);

  function automatic logic [N*N-1:0] set_row(input logic [N*N-1:0] g, input int r,
                                             input logic [N-1:0] v);
    logic [N*N-1:0] t;
    t = g;
    t[N*r +: N] = v;
    return t;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [N*N-1:0] g, input logic [GEN_W-1:0] gen,
                            input logic r, input logic s, input logic d, input logic [1:0] st);
    exp_q.push_back({g, gen, r, s, d, st});
    name_q.push_back(nm);
  endtask

  task automatic do_load(input logic [N*N-1:0] g);
    init_state = g;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  // Monitor: compares every pending expectation on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {grid, generation, running, stable, done, dbg_state};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got grid=%h gen=%0d run=%b stb=%b done=%b st=%0d want grid=%h gen=%0d run=%b stb=%b done=%b st=%0d",
                 nm, a[W-1 -: N*N], a[GEN_W+4:5], a[4], a[3], a[2], a[1:0],
                 e[W-1 -: N*N], e[GEN_W+4:5], e[4], e[3], e[2], e[1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    g_zero    = '0;
    g_blink_v = set_row(set_row(set_row(g_zero, 5, 16'h0020), 6, 16'h0020), 7, 16'h0020);
    g_blink_h = set_row(g_zero, 6, 16'h0070);
    g_block   = set_row(set_row(g_zero, 3, 16'h0018), 4, 16'h0018);

    reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    init_state = '0; max_gen = '0;
    tick(2);
    expect_now("power_on_reset", g_zero, 0, 0, 0, 0, ST_IDLE);
    reset = 1'b1;

    // Blinker: updates at k+4 and k+8.
    do_load(g_blink_v);
    expect_now("blinker_load", g_blink_v, 0, 0, 0, 0, ST_IDLE);
    do_start();
    expect_now("blinker_start", g_blink_v, 0, 1, 0, 0, ST_RUN);
    tick(3);
    expect_now("blinker_k3_no_update", g_blink_v, 0, 1, 0, 0, ST_RUN);
    tick(1);
    expect_now("blinker_k4_gen1", g_blink_h, 1, 1, 0, 0, ST_RUN);
    tick(4);
    expect_now("blinker_k8_gen2", g_blink_v, 2, 1, 0, 0, ST_RUN);

    // Reset in the middle of a run.
    tick(1);
    do_reset();
    expect_now("reset_mid_run", g_zero, 0, 0, 0, 0, ST_IDLE);

    // Generation limit 3: done at k+12 on the horizontal phase.
    max_gen = 16'd3;
    do_load(g_blink_v);
    do_start();
    tick(11);
    expect_now("maxgen_k11", g_blink_v, 2, 1, 0, 0, ST_RUN);
    tick(1);
    expect_now("maxgen_k12_done", g_blink_h, 3, 0, 0, 1, ST_DONE);

    // Restart from DONE keeps the grid, clears the count; load is ignored in RUN.
    do_start();
    expect_now("done_restart", g_blink_h, 0, 1, 0, 0, ST_RUN);
    tick(4);
    expect_now("restart_gen1", g_blink_v, 1, 1, 0, 0, ST_RUN);
    do_load(g_block);
    expect_now("load_ignored_in_run", g_blink_v, 1, 1, 0, 0, ST_RUN);

    // Pause sampled high at k+3..k+7; exit edge k+8 counts, update lands at k+9.
    do_reset();
    max_gen = '0;
    do_load(g_blink_v);
    do_start();
    tick(2);
    pause = 1'b1;
    tick(1);
    expect_now("pause_enter_hold", g_blink_v, 0, 0, 0, 0, ST_HOLD);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    expect_now("hold_k4_no_update", g_blink_v, 0, 0, 0, 0, ST_HOLD);
    tick(3);
    expect_now("hold_k7", g_blink_v, 0, 0, 0, 0, ST_HOLD);
    pause = 1'b0;
    tick(1);
    expect_now("hold_exit_k8", g_blink_v, 0, 1, 0, 0, ST_RUN);
    tick(1);
    expect_now("pause_update_k9", g_blink_h, 1, 1, 0, 0, ST_RUN);

    // Block is a still life: stable/done at first update, generation stays 0.
    do_reset();
    do_load(g_block);
    do_start();
    tick(4);
    expect_now("block_stable", g_block, 0, 0, 1, 1, ST_DONE);
    do_load(g_zero);
    expect_now("done_load_to_idle", g_zero, 0, 0, 0, 0, ST_IDLE);

    // load beats start in IDLE; an empty grid is stable on its first update.
    init_state = g_blink_v;
    load = 1'b1;
    start = 1'b1;
    tick(1);
    load = 1'b0;
    start = 1'b0;
    expect_now("load_beats_start", g_blink_v, 0, 0, 0, 0, ST_IDLE);
    do_load(g_zero);
    do_start();
    tick(3);
    expect_now("zero_k3", g_zero, 0, 1, 0, 0, ST_RUN);
    tick(1);
    expect_now("zero_stable", g_zero, 0, 0, 1, 1, ST_DONE);

    tick(2);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL undrained: %0d expectations never compared", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    if (n_fail == 0) $display("PASS");
    else             $display("FAIL: %0d mismatches", n_fail);
    $finish;
  end

endmodule
